// File: rtl/pipelined_adder_pkg.sv
// Shared configuration for the pipelined adder: default geometry, chunk
// derivation and the elaboration-time legality check.
package pipelined_adder_pkg;

    localparam int unsigned DEFAULT_WIDTH  = 32;
    localparam int unsigned DEFAULT_STAGES = 4;

    function automatic int unsigned chunk_width(input int unsigned width, input int unsigned stages);
        return (stages == 0) ? width : width / stages;
    endfunction

    function automatic bit cfg_ok(input int unsigned width, input int unsigned stages);
        return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/adder_chunk.sv
// W-bit ripple-carry slice; also exposes the carry into its top bit so the
// final slice can derive signed overflow.
module adder_chunk #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         c_in,
    output logic [W-1:0] sum,
    output logic         c_out,
    output logic         c_msb_in
);

    // Per-bit carry nets keep the chain free of self-referencing vectors.
    for (genvar i = 0; i < W; i++) begin : g_bit
        logic ci;
        logic co;
        if (i == 0) begin : g_lsb
            assign ci = c_in;
        end else begin : g_chain
            assign ci = g_bit[i-1].co;
        end
        full_adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (ci),
            .s    (sum[i]),
            .cout (co)
        );
    end

    assign c_out    = g_bit[W-1].co;
    assign c_msb_in = g_bit[W-1].ci;

endmodule

// File: rtl/full_adder.sv
// Single-bit full adder cell used to build the ripple chunks.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/pipelined_adder.sv
// Skewed-operand pipelined adder/subtractor: one CHUNK-bit ripple per stage,
// global stall on output backpressure, flags registered with the result.
module pipelined_adder
    import pipelined_adder_pkg::*;
#(
    parameter int unsigned WIDTH  = DEFAULT_WIDTH,
    parameter int unsigned STAGES = DEFAULT_STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int unsigned CHUNK = chunk_width(WIDTH, STAGES);

    if (!cfg_ok(WIDTH, STAGES)) begin : g_bad_cfg
        $error("pipelined_adder: need 1 <= STAGES <= WIDTH and WIDTH a multiple of STAGES");
    end

    logic             adv;
    logic [WIDTH-1:0] b_eff;
    logic             c0;

    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;
    assign b_eff    = sub ? ~b : b;
    assign c0       = sub ? 1'b1 : cin;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int unsigned DONE = (k + 1) * CHUNK;
        localparam int unsigned LEFT = WIDTH - k * CHUNK;

        logic             v_in;
        logic [LEFT-1:0]  a_in;
        logic [LEFT-1:0]  b_in;
        logic             c_in;
        logic [CHUNK-1:0] ch_sum;
        logic             ch_cout;
        logic [DONE-1:0]  sum_d;
        logic [DONE-1:0]  sum_q;
        logic             valid_q;

        if (k == 0) begin : g_head
            assign v_in  = in_valid;
            assign a_in  = a;
            assign b_in  = b_eff;
            assign c_in  = c0;
            assign sum_d = ch_sum;
        end else begin : g_link
            assign v_in  = g_stage[k-1].valid_q;
            assign a_in  = g_stage[k-1].g_fwd.a_q;
            assign b_in  = g_stage[k-1].g_fwd.b_q;
            assign c_in  = g_stage[k-1].g_fwd.carry_q;
            assign sum_d = {ch_sum, g_stage[k-1].sum_q};
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                valid_q <= 1'b0;
                sum_q   <= '0;
            end else if (adv) begin
                valid_q <= v_in;
                if (v_in) sum_q <= sum_d;
            end
        end

        // Inner stages carry only the operand chunks not yet consumed.
        if (k < STAGES - 1) begin : g_fwd
            logic [LEFT-CHUNK-1:0] a_q;
            logic [LEFT-CHUNK-1:0] b_q;
            logic                  carry_q;
            logic                  msb_carry_unused;

            adder_chunk #(.W(CHUNK)) u_chunk (
                .a        (a_in[CHUNK-1:0]),
                .b        (b_in[CHUNK-1:0]),
                .c_in     (c_in),
                .sum      (ch_sum),
                .c_out    (ch_cout),
                .c_msb_in (msb_carry_unused)
            );

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q     <= '0;
                    b_q     <= '0;
                    carry_q <= 1'b0;
                end else if (adv && v_in) begin
                    a_q     <= a_in[LEFT-1:CHUNK];
                    b_q     <= b_in[LEFT-1:CHUNK];
                    carry_q <= ch_cout;
                end
            end
        end else begin : g_last
            logic ch_cmsb;
            logic cout_q;
            logic ovf_q;
            logic zero_q;

            adder_chunk #(.W(CHUNK)) u_chunk (
                .a        (a_in[CHUNK-1:0]),
                .b        (b_in[CHUNK-1:0]),
                .c_in     (c_in),
                .sum      (ch_sum),
                .c_out    (ch_cout),
                .c_msb_in (ch_cmsb)
            );

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cout_q <= 1'b0;
                    ovf_q  <= 1'b0;
                    zero_q <= 1'b0;
                end else if (adv && v_in) begin
                    cout_q <= ch_cout;
                    ovf_q  <= ch_cmsb ^ ch_cout;
                    zero_q <= (sum_d == '0);
                end
            end
        end
    end

    assign out_valid = g_stage[STAGES-1].valid_q;
    assign sum       = g_stage[STAGES-1].sum_q;
    assign cout      = g_stage[STAGES-1].g_last.cout_q;
    assign ovf       = g_stage[STAGES-1].g_last.ovf_q;
    assign zero      = g_stage[STAGES-1].g_last.zero_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench: directed table, randomized backpressure stream,
// mid-flight reset and a geometry sweep against an arithmetic model.
module tb_pipelined_adder;

    typedef struct packed {
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } res_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic        sub;
        res_t        exp;
    } vec_t;

    localparam int unsigned MAIN_STAGES = 4;
    localparam int unsigned N_STREAM    = 100;
    localparam int unsigned N_SWEEP     = 300;

    int n_vec = 0;
    int n_err = 0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        cin = 1'b0;
    logic        sub = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;

    logic [2:0]       sw_valid = '0;
    logic [2:0]       sw_rdy;
    logic [2:0]       sw_ov;
    logic [2:0]       sw_cout;
    logic [2:0]       sw_ovf;
    logic [2:0]       sw_zero;
    logic [2:0]       sw_cin = '0;
    logic [2:0]       sw_sub = '0;
    logic [2:0][63:0] sw_a = '0;
    logic [2:0][63:0] sw_b = '0;
    logic             sw_oready = 1'b1;
    logic [7:0]       s8;
    logic [15:0]      s16;
    logic [63:0]      s64;

    always #5 clk = ~clk;

    pipelined_adder #(.WIDTH(32), .STAGES(MAIN_STAGES)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
    );

    pipelined_adder #(.WIDTH(8), .STAGES(1)) u_w8 (
        .clk(clk), .rst_n(rst_n), .in_valid(sw_valid[0]), .in_ready(sw_rdy[0]),
        .a(sw_a[0][7:0]), .b(sw_b[0][7:0]), .cin(sw_cin[0]), .sub(sw_sub[0]),
        .out_valid(sw_ov[0]), .out_ready(sw_oready), .sum(s8),
        .cout(sw_cout[0]), .ovf(sw_ovf[0]), .zero(sw_zero[0])
    );

    pipelined_adder #(.WIDTH(16), .STAGES(2)) u_w16 (
        .clk(clk), .rst_n(rst_n), .in_valid(sw_valid[1]), .in_ready(sw_rdy[1]),
        .a(sw_a[1][15:0]), .b(sw_b[1][15:0]), .cin(sw_cin[1]), .sub(sw_sub[1]),
        .out_valid(sw_ov[1]), .out_ready(sw_oready), .sum(s16),
        .cout(sw_cout[1]), .ovf(sw_ovf[1]), .zero(sw_zero[1])
    );

    pipelined_adder #(.WIDTH(64), .STAGES(8)) u_w64 (
        .clk(clk), .rst_n(rst_n), .in_valid(sw_valid[2]), .in_ready(sw_rdy[2]),
        .a(sw_a[2]), .b(sw_b[2]), .cin(sw_cin[2]), .sub(sw_sub[2]),
        .out_valid(sw_ov[2]), .out_ready(sw_oready), .sum(s64),
        .cout(sw_cout[2]), .ovf(sw_ovf[2]), .zero(sw_zero[2])
    );

    // Reference: plain modular arithmetic on w-bit two's-complement values.
    function automatic res_t model(input logic [63:0] x, input logic [63:0] y,
                                   input logic c, input logic s, input int unsigned w);
        logic [64:0] mask;
        logic [64:0] xa;
        logic [64:0] yb;
        logic [64:0] full;
        res_t        r;
        mask   = (65'd1 << w) - 65'd1;
        xa     = {1'b0, x} & mask;
        yb     = (s ? ~{1'b0, y} : {1'b0, y}) & mask;
        full   = xa + yb + (s ? 65'd1 : {64'd0, c});
        r.sum  = full[63:0] & mask[63:0];
        r.cout = full[w];
        r.zero = (r.sum == 64'd0);
        r.ovf  = (xa[w-1] == yb[w-1]) && (r.sum[w-1] != xa[w-1]);
        return r;
    endfunction

    function automatic res_t mk(input logic [63:0] s, input logic c, input logic o, input logic z);
        res_t r;
        r.sum = s; r.cout = c; r.ovf = o; r.zero = z;
        return r;
    endfunction

    function automatic res_t got_main();
        return mk({32'd0, sum}, cout, ovf, zero);
    endfunction

    function automatic res_t got_sw(input int i);
        logic [63:0] s;
        case (i)
            0:       s = {56'd0, s8};
            1:       s = {48'd0, s16};
            default: s = s64;
        endcase
        return mk(s, sw_cout[i], sw_ovf[i], sw_zero[i]);
    endfunction

    task automatic check_res(input string name, input res_t got, input res_t exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got sum=%h cout=%b ovf=%b zero=%b, want sum=%h cout=%b ovf=%b zero=%b",
                     name, got.sum, got.cout, got.ovf, got.zero, exp.sum, exp.cout, exp.ovf, exp.zero);
        end
    endtask

    task automatic check_val(input string name, input longint got, input longint exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", name, got, exp);
        end
    endtask

    // One operation into an empty pipeline with out_ready high; checks latency and result.
    task automatic apply_one(input string name, input logic [31:0] ta, input logic [31:0] tb,
                             input logic tc, input logic ts, input res_t exp);
        int unsigned lat;
        @(negedge clk);
        a = ta; b = tb; cin = tc; sub = ts; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 12) begin
            @(posedge clk);
            #1 lat++;
        end
        check_val({name, "_latency"}, lat, MAIN_STAGES);
        check_res(name, got_main(), exp);
    endtask

    vec_t        tbl[10];
    res_t        expq[$];
    bit          hv[3][N_SWEEP];
    res_t        he[3][N_SWEEP];
    int unsigned sw_w[3] = '{8, 16, 64};
    int unsigned sw_s[3] = '{1, 2, 8};

    initial begin
        int unsigned sent;
        int unsigned recvd;
        int unsigned cyc;
        bit          last_acc;
        bit          ghost;

        tbl[0] = '{32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, mk(64'h0000_0000, 1'b1, 1'b0, 1'b1)};
        tbl[1] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, mk(64'h7FFF_FFFF, 1'b1, 1'b1, 1'b0)};
        tbl[2] = '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, mk(64'hFFFF_FFFE, 1'b0, 1'b0, 1'b0)};
        tbl[3] = '{32'h00FF_FFFF, 32'h0000_0001, 1'b0, 1'b0, mk(64'h0100_0000, 1'b0, 1'b0, 1'b0)};
        tbl[4] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, mk(64'h8000_0000, 1'b0, 1'b1, 1'b0)};
        tbl[5] = '{32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, mk(64'h2345_678A, 1'b0, 1'b0, 1'b0)};
        tbl[6] = '{32'h0000_000A, 32'h0000_0003, 1'b1, 1'b1, mk(64'h0000_0007, 1'b1, 1'b0, 1'b0)};
        tbl[7] = '{32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1'b1, mk(64'h0000_0000, 1'b1, 1'b0, 1'b1)};
        tbl[8] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, mk(64'hFFFF_FFFF, 1'b1, 1'b0, 1'b0)};
        tbl[9] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, mk(64'h0000_0000, 1'b1, 1'b1, 1'b1)};

        // Reset state
        #2 rst_n = 1'b0;
        #1;
        check_res("reset_outputs", got_main(), mk(64'd0, 1'b0, 1'b0, 1'b0));
        check_val("reset_out_valid", out_valid, 0);
        check_val("reset_in_ready", in_ready, 1);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        // Directed table
        for (int i = 0; i < 10; i++)
            apply_one($sformatf("table%0d", i), tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub, tbl[i].exp);

        // Back-to-back random stream under random backpressure
        sent = 0; recvd = 0; cyc = 0; last_acc = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        while (recvd < N_STREAM && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            if (in_valid && last_acc) in_valid = 1'b0;
            if (!in_valid && sent < N_STREAM) begin
                a = $urandom; b = $urandom;
                cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
                in_valid = 1'b1;
            end
            out_ready = 1'($urandom_range(0, 1));
            #1;
            if (out_valid && !out_ready) check_val("stall_in_ready", in_ready, 0);
            if (out_valid) begin
                if (expq.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL stream_spurious: got out_valid=1, want 0 (no result pending)");
                end else begin
                    check_res($sformatf("stream%0d", recvd), got_main(), expq[0]);
                end
            end
            if (out_valid && out_ready && expq.size() > 0) begin
                void'(expq.pop_front());
                recvd++;
            end
            last_acc = in_valid && in_ready;
            if (last_acc) begin
                expq.push_back(model({32'd0, a}, {32'd0, b}, cin, sub, 32));
                sent++;
            end
        end
        check_val("stream_received", recvd, N_STREAM);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (MAIN_STAGES + 1) @(negedge clk);

        // Reset with operations in flight
        a = 32'hF000_0000; b = 32'h2000_0000; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(negedge clk) a = 32'h0000_0003;
        @(negedge clk) a = 32'h0000_0004;
        @(negedge clk) in_valid = 1'b0;
        @(posedge clk);
        #1 check_val("inflight_out_valid", out_valid, 1);
        out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_val("midreset_out_valid", out_valid, 0);
        check_res("midreset_outputs", got_main(), mk(64'd0, 1'b0, 1'b0, 1'b0));
        @(posedge clk);
        @(negedge clk) begin rst_n = 1'b1; out_ready = 1'b1; end
        ghost = 1'b0;
        repeat (8) begin
            @(posedge clk);
            #1 if (out_valid) ghost = 1'b1;
        end
        check_val("no_ghost_after_reset", ghost, 0);
        apply_one("post_reset", 32'h0000_1234, 32'h0000_0FFF, 1'b1, 1'b0,
                  model(64'h1234, 64'h0FFF, 1'b1, 1'b0, 32));

        // Geometry sweep with out_ready held high: exact latency and full throughput
        for (int c = 0; c < int'(N_SWEEP); c++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                check_val($sformatf("sweep%0d_in_ready", sw_w[i]), sw_rdy[i], 1);
                if (c >= int'(sw_s[i])) begin
                    check_val($sformatf("sweep%0d_valid_c%0d", sw_w[i], c), sw_ov[i],
                              hv[i][c - int'(sw_s[i])]);
                    if (hv[i][c - int'(sw_s[i])])
                        check_res($sformatf("sweep%0d_c%0d", sw_w[i], c), got_sw(i),
                                  he[i][c - int'(sw_s[i])]);
                end
                sw_valid[i] = ($urandom_range(0, 3) != 0);
                sw_a[i]     = {$urandom, $urandom};
                sw_b[i]     = ($urandom_range(0, 7) == 0) ? sw_a[i] : {$urandom, $urandom};
                sw_cin[i]   = 1'($urandom_range(0, 1));
                sw_sub[i]   = 1'($urandom_range(0, 1));
                hv[i][c]    = sw_valid[i];
                he[i][c]    = model(sw_a[i], sw_b[i], sw_cin[i], sw_sub[i], sw_w[i]);
            end
        end
        sw_valid = '0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
